// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with execute-operand forwarding, placed directly
//   ahead of the ALU. Decoded operands and control are captured on every rising
//   edge unless the stage is stalled or flushed. ALU operands are then selected
//   combinationally from the EX/MEM and MEM/WB results.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   StallE, FlushE        hold / bubble controls from the hazard unit
//   ValidD, RD1D, RD2D,   decode-slot instruction: qualifier, operands,
//   ImmExtD, PCD, Rs1D,   immediate, PC, register indices, control bundle,
//   Rs2D, RdD, CtrlD,     ALU operation and operand-B select
//   ALUControlD, ALUSrcD
//   ALUResultM, RdM,      EX/MEM forward source
//   RegWriteM
//   ResultW, RdW,         MEM/WB forward source
//   RegWriteW
//   SrcAE, SrcBE,         ALU operands and store data after forwarding
//   WriteDataE
//   ALUControlE, PCE,     registered execute-slot fields
//   RdE, CtrlE, ValidE
//
// Slot protocol: ValidD/ValidE qualify the decode and execute slots. Nothing
//   flows backwards here. On each rising edge FlushE loads a bubble (all E
//   registers zero, so ValidE=0 and RegWrite=CtrlE[0]=0) and takes priority
//   over StallE. StallE holds every E register. Otherwise the decode slot is
//   loaded, and an invalid decode slot (ValidD=0) loads as a bubble.
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              ValidD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [REG_W-1:0]  Rs1D,
  input  logic [REG_W-1:0]  Rs2D,
  input  logic [REG_W-1:0]  RdD,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [2:0]        ALUControlD,
  input  logic              ALUSrcD,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [REG_W-1:0]  RdM,
  input  logic              RegWriteM,
  input  logic [XLEN-1:0]   ResultW,
  input  logic [REG_W-1:0]  RdW,
  input  logic              RegWriteW,
  output logic [XLEN-1:0]   SrcAE,
  output logic [XLEN-1:0]   SrcBE,
  output logic [XLEN-1:0]   WriteDataE,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   PCE,
  output logic [REG_W-1:0]  RdE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic              ValidE
);

  // All execute-slot state in one record so that bubble = '0 and hold = keep.
  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [2:0]        alu_ctl;
    logic              alu_src;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
  } e_regs_t;

  e_regs_t e_q;
  e_regs_t e_d;

  always_comb begin
    e_d = e_q;
    if (FlushE) begin
      e_d = '0;
    end else if (!StallE) begin
      if (ValidD) begin
        e_d.valid   = 1'b1;
        e_d.ctrl    = CtrlD;
        e_d.alu_ctl = ALUControlD;
        e_d.alu_src = ALUSrcD;
        e_d.pc      = PCD;
        e_d.rd1     = RD1D;
        e_d.rd2     = RD2D;
        e_d.imm     = ImmExtD;
        e_d.rs1     = Rs1D;
        e_d.rs2     = Rs2D;
        e_d.rd      = RdD;
      end else begin
        e_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
    end else begin
      e_q <= e_d;
    end
  end

  // Forwarding: the younger producer (EX/MEM) wins over MEM/WB. Register x0 is
  // never forwarded because its architectural value is always zero.
  logic hit_a_m, hit_a_w, hit_b_m, hit_b_w;

  assign hit_a_m = RegWriteM && (RdM != '0) && (RdM == e_q.rs1);
  assign hit_a_w = RegWriteW && (RdW != '0) && (RdW == e_q.rs1);
  assign hit_b_m = RegWriteM && (RdM != '0) && (RdM == e_q.rs2);
  assign hit_b_w = RegWriteW && (RdW != '0) && (RdW == e_q.rs2);

  always_comb begin
    SrcAE = e_q.rd1;
    if (hit_a_m) begin
      SrcAE = ALUResultM;
    end else if (hit_a_w) begin
      SrcAE = ResultW;
    end
  end

  always_comb begin
    WriteDataE = e_q.rd2;
    if (hit_b_m) begin
      WriteDataE = ALUResultM;
    end else if (hit_b_w) begin
      WriteDataE = ResultW;
    end
  end

  assign SrcBE       = e_q.alu_src ? e_q.imm : WriteDataE;
  assign ALUControlE = e_q.alu_ctl;
  assign PCE         = e_q.pc;
  assign RdE         = e_q.rd;
  assign CtrlE       = e_q.ctrl;
  assign ValidE      = e_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed bench for id_ex_stage. The driver sets up each case and pushes a
//   hand-computed expected output vector. A separate monitor pops that vector
//   on the falling clock edge and compares it with the DUT outputs.
//   Packed vector layout: {SrcAE, SrcBE, WriteDataE, ALUControlE, PCE, RdE,
//   CtrlE, ValidE}.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int XLEN   = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 6;
  localparam int W      = 4 * XLEN + 3 + REG_W + CTRL_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              StallE, FlushE, ValidD, ALUSrcD, RegWriteM, RegWriteW;
  logic [XLEN-1:0]   RD1D, RD2D, ImmExtD, PCD, ALUResultM, ResultW;
  logic [REG_W-1:0]  Rs1D, Rs2D, RdD, RdM, RdW;
  logic [CTRL_W-1:0] CtrlD;
  logic [2:0]        ALUControlD;
  logic [XLEN-1:0]   SrcAE, SrcBE, WriteDataE, PCE;
  logic [2:0]        ALUControlE;
  logic [REG_W-1:0]  RdE;
  logic [CTRL_W-1:0] CtrlE;
  logic              ValidE;

  id_ex_stage #(.XLEN(XLEN), .REG_W(REG_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .Rs1D(Rs1D),
    .Rs2D(Rs2D), .RdD(RdD), .CtrlD(CtrlD), .ALUControlD(ALUControlD),
    .ALUSrcD(ALUSrcD), .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
    .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW), .SrcAE(SrcAE),
    .SrcBE(SrcBE), .WriteDataE(WriteDataE), .ALUControlE(ALUControlE), .PCE(PCE),
    .RdE(RdE), .CtrlE(CtrlE), .ValidE(ValidE)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           total = 0;
  int           bad = 0;

  function automatic logic [W-1:0] mk(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                      input logic [XLEN-1:0] wd, input logic [2:0] alu,
                                      input logic [XLEN-1:0] pc, input logic [REG_W-1:0] rd,
                                      input logic [CTRL_W-1:0] ctrl, input logic v);
    return {a, b, wd, alu, pc, rd, ctrl, v};
  endfunction

  // Monitor: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] got;
      logic [W-1:0] exp;
      string        nm;
      got = {SrcAE, SrcBE, WriteDataE, ALUControlE, PCE, RdE, CtrlE, ValidE};
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL %s: got=%h expected=%h", nm, got, exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push an expectation and let the monitor consume it at the next falling edge.
  task automatic check(input string nm, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  task automatic drive_d(input logic v, input logic [XLEN-1:0] rd1, input logic [XLEN-1:0] rd2,
                         input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc,
                         input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                         input logic [REG_W-1:0] rd, input logic [CTRL_W-1:0] ctrl,
                         input logic [2:0] alu, input logic alu_src);
    ValidD = v; RD1D = rd1; RD2D = rd2; ImmExtD = imm; PCD = pc;
    Rs1D = rs1; Rs2D = rs2; RdD = rd; CtrlD = ctrl; ALUControlD = alu; ALUSrcD = alu_src;
  endtask

  task automatic fwd(input logic wm, input logic [REG_W-1:0] rdm, input logic [XLEN-1:0] resm,
                     input logic ww, input logic [REG_W-1:0] rdw, input logic [XLEN-1:0] resw);
    RegWriteM = wm; RdM = rdm; ALUResultM = resm;
    RegWriteW = ww; RdW = rdw; ResultW = resw;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    StallE = 1'b0; FlushE = 1'b0;
    drive_d(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, 3'b000, 1'b0);
    fwd(1'b0, '0, '0, 1'b0, '0, '0);

    // Reset state
    step();
    check("reset", mk(32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 5'd0, 6'h00, 1'b0));
    rst_n = 1'b1;

    // 1) Plain load, no hazards
    drive_d(1'b1, 32'd5, 32'd7, 32'h8, 32'h100, 5'd1, 5'd2, 5'd4, 6'h01, 3'b000, 1'b0);
    step();
    check("t1_basic", mk(32'd5, 32'd7, 32'd7, 3'b000, 32'h100, 5'd4, 6'h01, 1'b1));

    // 2) Forwarding priority on rs1, then forwarding on rs2
    drive_d(1'b1, 32'hA, 32'hB, 32'h0, 32'h104, 5'd3, 5'd5, 5'd6, 6'h03, 3'b010, 1'b0);
    step();
    fwd(1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20);
    check("t2_m_over_w", mk(32'h10, 32'hB, 32'hB, 3'b010, 32'h104, 5'd6, 6'h03, 1'b1));
    fwd(1'b0, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20);
    check("t2_w_only", mk(32'h20, 32'hB, 32'hB, 3'b010, 32'h104, 5'd6, 6'h03, 1'b1));
    fwd(1'b0, 5'd3, 32'h10, 1'b0, 5'd3, 32'h20);
    check("t2_no_fwd", mk(32'hA, 32'hB, 32'hB, 3'b010, 32'h104, 5'd6, 6'h03, 1'b1));
    fwd(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0);
    check("t2_fwd_b_m", mk(32'hA, 32'h55, 32'h55, 3'b010, 32'h104, 5'd6, 6'h03, 1'b1));
    fwd(1'b0, '0, '0, 1'b0, '0, '0);

    // 3) x0 is never forwarded
    drive_d(1'b1, 32'h0, 32'h3, 32'h0, 32'h108, 5'd0, 5'd0, 5'd1, 6'h01, 3'b001, 1'b0);
    step();
    fwd(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE);
    check("t3_x0", mk(32'h0, 32'h3, 32'h3, 3'b001, 32'h108, 5'd1, 6'h01, 1'b1));
    fwd(1'b0, '0, '0, 1'b0, '0, '0);

    // 4) Stall holds for two edges; flush beats stall
    drive_d(1'b1, 32'h70, 32'h80, 32'h0, 32'h10C, 5'd7, 5'd8, 5'd9, 6'h21, 3'b110, 1'b0);
    step();
    check("t4_load", mk(32'h70, 32'h80, 32'h80, 3'b110, 32'h10C, 5'd9, 6'h21, 1'b1));
    drive_d(1'b1, 32'h999, 32'h888, 32'h7, 32'h200, 5'd11, 5'd12, 5'd2, 6'h3E, 3'b011, 1'b1);
    StallE = 1'b1;
    step();
    check("t4_stall1", mk(32'h70, 32'h80, 32'h80, 3'b110, 32'h10C, 5'd9, 6'h21, 1'b1));
    step();
    check("t4_stall2", mk(32'h70, 32'h80, 32'h80, 3'b110, 32'h10C, 5'd9, 6'h21, 1'b1));
    FlushE = 1'b1;
    step();
    check("t4_flush_wins", mk(32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 5'd0, 6'h00, 1'b0));
    StallE = 1'b0; FlushE = 1'b0;

    // 5) Immediate on SrcBE, forwarded rs2 on WriteDataE
    drive_d(1'b1, 32'h40, 32'h99, 32'hFFFF_FFFC, 32'h110, 5'd4, 5'd9, 5'd10, 6'h05, 3'b000, 1'b1);
    step();
    fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h44);
    check("t5_imm_fwd", mk(32'h40, 32'hFFFF_FFFC, 32'h44, 3'b000, 32'h110, 5'd10, 6'h05, 1'b1));
    fwd(1'b0, '0, '0, 1'b0, '0, '0);

    // Invalid decode slot loads a bubble
    drive_d(1'b0, 32'h123, 32'h456, 32'h9, 32'h114, 5'd13, 5'd14, 5'd15, 6'h3F, 3'b111, 1'b0);
    step();
    check("valid0_bubble", mk(32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 5'd0, 6'h00, 1'b0));

    // 6) Asynchronous reset mid-cycle
    drive_d(1'b1, 32'h31, 32'h32, 32'h0, 32'h118, 5'd1, 5'd2, 5'd3, 6'h09, 3'b101, 1'b0);
    step();
    check("t6_pre", mk(32'h31, 32'h32, 32'h32, 3'b101, 32'h118, 5'd3, 6'h09, 1'b1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    check("t6_async_rst", mk(32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 5'd0, 6'h00, 1'b0));

    // Normal operation resumes after reset
    drive_d(1'b1, 32'h5A, 32'h6B, 32'h0, 32'h11C, 5'd6, 5'd7, 5'd8, 6'h11, 3'b100, 1'b0);
    step();
    check("post_rst_load", mk(32'h5A, 32'h6B, 32'h6B, 3'b100, 32'h11C, 5'd8, 6'h11, 1'b1));

    // Drain: every pushed expectation must have been consumed
    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: timed out, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
